// File: rtl/rain_window_ctrl.sv
// Motorised window controller: closes on rain or user command, optionally reopens after a
// dry spell, and latches a fault when travel is implausible or takes too long.
module rain_window_ctrl #(
   parameter int MOTOR_TIMEOUT = 50,
   parameter int DRY_HOLD      = 20,
   parameter int AUTO_REOPEN   = 1,
   parameter int CNT_W         = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rain_alarm,
   input  logic       manual_open,
   input  logic       manual_close,
   input  logic       open_limit,
   input  logic       closed_limit,
   output logic       motor_open,
   output logic       motor_close,
   output logic [1:0] window_state,
   output logic       fault
);

   typedef enum logic [2:0] {
      S_OPEN,
      S_CLOSING,
      S_CLOSED,
      S_OPENING,
      S_FAULT
   } state_t;

   localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(MOTOR_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] DRY_LAST    = CNT_W'(DRY_HOLD - 1);
   localparam logic [CNT_W-1:0] DRY_MAX     = '1;
   localparam logic             AUTO_EN     = (AUTO_REOPEN != 0);

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] travel_cnt_reg, travel_cnt_next;
   logic [CNT_W-1:0] dry_cnt_reg, dry_cnt_next;
   logic             rain_closed_reg, rain_closed_next;
   logic             both_limits;
   logic             moving_next;

   assign both_limits = open_limit & closed_limit;

   always_comb begin
      state_next       = state_reg;
      rain_closed_next = rain_closed_reg;
      case (state_reg)
         S_OPEN: begin
            if (rain_alarm || manual_close) begin
               state_next       = S_CLOSING;
               rain_closed_next = rain_alarm;
            end
         end
         S_CLOSING: begin
            // A limit switch reached in the timeout cycle still counts as a good close.
            if (both_limits)
               state_next = S_FAULT;
            else if (closed_limit)
               state_next = S_CLOSED;
            else if (travel_cnt_reg == TRAVEL_LAST)
               state_next = S_FAULT;
         end
         S_CLOSED: begin
            if ((manual_open && !rain_alarm && !manual_close) ||
                (AUTO_EN && rain_closed_reg && (dry_cnt_reg == DRY_LAST))) begin
               state_next       = S_OPENING;
               rain_closed_next = 1'b0;
            end
         end
         S_OPENING: begin
            if (both_limits)
               state_next = S_FAULT;
            else if (rain_alarm || manual_close) begin
               state_next       = S_CLOSING;
               rain_closed_next = rain_alarm;
            end else if (open_limit)
               state_next = S_OPEN;
            else if (travel_cnt_reg == TRAVEL_LAST)
               state_next = S_FAULT;
         end
         S_FAULT: state_next = S_FAULT;
         default: state_next = S_FAULT;
      endcase
   end

   // Travel time restarts on every entry into a moving state, including a reversal.
   assign moving_next = (state_next == S_CLOSING) || (state_next == S_OPENING);

   always_comb begin
      travel_cnt_next = '0;
      if (moving_next && (state_next == state_reg))
         travel_cnt_next = travel_cnt_reg + CNT_W'(1);
   end

   always_comb begin
      dry_cnt_next = '0;
      if ((state_reg == S_CLOSED) && (state_next == S_CLOSED) && rain_closed_reg && !rain_alarm)
         dry_cnt_next = (dry_cnt_reg == DRY_MAX) ? dry_cnt_reg : dry_cnt_reg + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg       <= S_CLOSING;
         travel_cnt_reg  <= '0;
         dry_cnt_reg     <= '0;
         rain_closed_reg <= 1'b0;
         motor_open      <= 1'b0;
         motor_close     <= 1'b0;
         window_state    <= 2'b01;
         fault           <= 1'b0;
      end else begin
         state_reg       <= state_next;
         travel_cnt_reg  <= travel_cnt_next;
         dry_cnt_reg     <= dry_cnt_next;
         rain_closed_reg <= rain_closed_next;
         motor_open      <= (state_next == S_OPENING);
         motor_close     <= (state_next == S_CLOSING);
         fault           <= (state_next == S_FAULT);
         case (state_next)
            S_OPEN:   window_state <= 2'b00;
            S_CLOSED: window_state <= 2'b10;
            S_FAULT:  window_state <= 2'b11;
            default:  window_state <= 2'b01;
         endcase
      end
   end

endmodule
